rf_multiport_scoreboard: RTL and testbench

//  Parametrised integer register file for the pipelined RV64 NPC core: NUM_RPORTS read ports, two writeback ports,

---
 rtl/rf_multiport_scoreboard.sv | 150 +++++++++++++++
 tb/tb_rf_multiport_scoreboard.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_multiport_scoreboard.sv
// ----------------------------------------------------------------------------
// rf_multiport_scoreboard
//
// Integer register file for the pipelined RV64 NPC core. It has NUM_RPORTS
// combinational read ports and two writeback ports. It can optionally forward
// writeback data to reads in the same cycle. A per-register busy scoreboard is
// set by decode (issue) and cleared by writeback or flush. Register x0 always
// reads as zero and is never busy.
//
// Parameters
//   ADDR_WIDTH  register index width (2**ADDR_WIDTH registers)
//   DATA_WIDTH  register width
//   NUM_RPORTS  number of read ports, 1..4
//   BYPASS      1: same-cycle writeback data and busy-clear are forwarded to reads
//
// Ports
//   clk, reset                 rising-edge clock; synchronous active-low reset
//   wb0_wen/addr/data          writeback port 0 (older result)
//   wb1_wen/addr/data          writeback port 1 (younger result; wins on collision)
//   rd_ren[NUM_RPORTS]         per-port read enable
//   rd_addr                    packed read indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data                    packed read data,    port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rd_busy[NUM_RPORTS]        addressed register has an outstanding producer
//   issue_vld, issue_addr      mark destination register busy
//   flush                      clear every busy bit
// ----------------------------------------------------------------------------
module rf_multiport_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_RPORTS = 2,
  parameter int BYPASS     = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wb0_wen,
  input  logic [ADDR_WIDTH-1:0]            wb0_addr,
  input  logic [DATA_WIDTH-1:0]            wb0_data,
  input  logic                             wb1_wen,
  input  logic [ADDR_WIDTH-1:0]            wb1_addr,
  input  logic [DATA_WIDTH-1:0]            wb1_data,
  input  logic [NUM_RPORTS-1:0]            rd_ren,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RPORTS-1:0]            rd_busy,
  input  logic                             issue_vld,
  input  logic [ADDR_WIDTH-1:0]            issue_addr,
  input  logic                             flush
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;

  // Qualified writes. Writes to x0 are dropped here, so x0 is never stored
  // and never forwarded.
  logic wb0_act;
  logic wb1_act;
  logic iss_act;

  assign wb0_act = wb0_wen && (wb0_addr != '0);
  assign wb1_act = wb1_wen && (wb1_addr != '0);
  assign iss_act = issue_vld && (issue_addr != '0);

  // --------------------------------------------------------------------------
  // Storage next state. wb1 is applied after wb0, so wb1 wins when both ports
  // target the same register.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
    end
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_d[r] = '0;
      end
    end else begin
      if (wb0_act) regs_d[wb0_addr] = wb0_data;
      if (wb1_act) regs_d[wb1_addr] = wb1_data;
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard next state. Writeback clears are applied first and the issue
  // set is applied after them. This lets a new producer override a retiring
  // one for the same register. Flush overrides both. Writes never wait on
  // busy; the scoreboard only tells decode when a hazard exists.
  // --------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    if (!reset || flush) begin
      busy_d = '0;
    end else begin
      if (wb0_act) busy_d[wb0_addr]   = 1'b0;
      if (wb1_act) busy_d[wb1_addr]   = 1'b0;
      if (iss_act) busy_d[issue_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_q[r] <= regs_d[r];
    end
    busy_q <= busy_d;
  end

  // --------------------------------------------------------------------------
  // Read ports. Reads are fully combinational. Each port is gated to zero
  // during reset, when it is disabled, or when it addresses x0.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_RPORTS; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] idx;
    logic                  live;
    logic                  hit0;
    logic                  hit1;
    logic [DATA_WIDTH-1:0] data_sel;
    logic                  busy_sel;

    assign idx  = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign live = reset && rd_ren[i] && (idx != '0);
    assign hit0 = wb0_act && (wb0_addr == idx);
    assign hit1 = wb1_act && (wb1_addr == idx);

    if (BYPASS != 0) begin : g_byp
      // The younger writeback (wb1) has priority over wb0 for forwarding.
      always_comb begin
        data_sel = regs_q[idx];
        if (hit0) data_sel = wb0_data;
        if (hit1) data_sel = wb1_data;
        busy_sel = busy_q[idx] & ~(hit0 | hit1);
      end
    end else begin : g_nobyp
      // Without bypass, written data becomes visible one cycle later.
      // hit0/hit1 are intentionally unused in this configuration.
      logic unused_hits;
      assign unused_hits = hit0 ^ hit1;
      always_comb begin
        data_sel = regs_q[idx];
        busy_sel = busy_q[idx];
      end
    end

    assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = live ? data_sel : '0;
    assign rd_busy[i]                          = live & busy_sel;
  end

endmodule

// File: tb/tb_rf_multiport_scoreboard.sv
module tb_rf_multiport_scoreboard;

  localparam int AW = 5;
  localparam int DW = 64;
  localparam int NP = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           wb0_wen, wb1_wen;
  logic [AW-1:0]  wb0_addr, wb1_addr;
  logic [DW-1:0]  wb0_data, wb1_data;
  logic [NP-1:0]  rd_ren;
  logic [NP*AW-1:0] rd_addr;
  logic [NP*DW-1:0] rd_data;
  logic [NP-1:0]  rd_busy;
  logic           issue_vld;
  logic [AW-1:0]  issue_addr;
  logic           flush;

  // Second instance without bypass, sharing ports 0/1 of the stimulus
  logic [2*DW-1:0] nb_data;
  logic [1:0]      nb_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_multiport_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NP), .BYPASS(1)) dut (
    .clk(clk), .reset(reset),
    .wb0_wen(wb0_wen), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_wen(wb1_wen), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .rd_ren(rd_ren), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .issue_vld(issue_vld), .issue_addr(issue_addr), .flush(flush)
  );

  rf_multiport_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RPORTS(2), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset),
    .wb0_wen(wb0_wen), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_wen(wb1_wen), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .rd_ren(rd_ren[1:0]), .rd_addr(rd_addr[2*AW-1:0]), .rd_data(nb_data), .rd_busy(nb_busy),
    .issue_vld(issue_vld), .issue_addr(issue_addr), .flush(flush)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb0_wen = 0; wb0_addr = '0; wb0_data = '0;
    wb1_wen = 0; wb1_addr = '0; wb1_data = '0;
    issue_vld = 0; issue_addr = '0; flush = 0;
  endtask

  task automatic set_addr(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  function automatic logic [DW-1:0] dd(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] nd(input int p);
    return nb_data[p*DW +: DW];
  endfunction

  initial begin
    idle();
    reset = 0;
    rd_ren = '1;
    for (int p = 0; p < NP; p++) set_addr(p, 5);
    tick(); tick();
    #1;
    chk("rst_data", rd_data[DW-1:0], 64'h0);
    chk("rst_busy", 64'(rd_busy), 64'h0);

    // 1: write x5, mark busy, then reset clears both
    reset = 1;
    wb0_wen = 1; wb0_addr = 5; wb0_data = 64'hAA;
    #1;
    chk("x5_bypass", dd(0), 64'hAA);
    chk("x5_nobyp_old", nd(0), 64'h0);
    tick();
    idle();
    issue_vld = 1; issue_addr = 5;
    #1;
    chk("x5_stored", dd(0), 64'hAA);
    chk("x5_stored_nb", nd(0), 64'hAA);
    chk("x5_busy_same_cycle", 64'(rd_busy[0]), 64'h0);
    tick();
    idle();
    #1;
    chk("x5_busy", 64'(rd_busy[0]), 64'h1);
    chk("x5_busy_nb", 64'(nb_busy[0]), 64'h1);
    reset = 0;
    #1;
    chk("rst_force_data", dd(0), 64'h0);
    chk("rst_force_busy", 64'(rd_busy), 64'h0);
    tick(); tick();
    reset = 1;
    #1;
    chk("x5_after_rst", dd(0), 64'h0);
    chk("busy_after_rst", 64'(rd_busy), 64'h0);

    // 2: x0 is hard-wired zero and never busy
    wb0_wen = 1; wb0_addr = 0; wb0_data = 64'hFFFF;
    issue_vld = 1; issue_addr = 0;
    for (int p = 0; p < NP; p++) set_addr(p, 0);
    #1;
    chk("x0_read_wcycle", dd(0), 64'h0);
    tick();
    idle();
    #1;
    chk("x0_read", dd(0), 64'h0);
    chk("x0_read_p3", dd(3), 64'h0);
    chk("x0_busy", 64'(rd_busy), 64'h0);
    chk("x0_busy_nb", 64'(nb_busy), 64'h0);

    // 3: both writeback ports hit x7, wb1 wins
    set_addr(0, 7);
    wb0_wen = 1; wb0_addr = 7; wb0_data = 64'h11;
    wb1_wen = 1; wb1_addr = 7; wb1_data = 64'h22;
    #1;
    chk("coll_bypass", dd(0), 64'h22);
    chk("coll_nobyp_old", nd(0), 64'h0);
    tick();
    idle();
    #1;
    chk("coll_stored", dd(0), 64'h22);
    chk("coll_stored_nb", nd(0), 64'h22);

    // 4: issue x3, then writeback clears busy (bypassed same cycle)
    set_addr(0, 3);
    issue_vld = 1; issue_addr = 3;
    tick();
    idle();
    #1;
    chk("x3_busy", 64'(rd_busy[0]), 64'h1);
    wb1_wen = 1; wb1_addr = 3; wb1_data = 64'h5;
    #1;
    chk("x3_busy_byp_clear", 64'(rd_busy[0]), 64'h0);
    chk("x3_data_byp", dd(0), 64'h5);
    chk("x3_busy_nb_held", 64'(nb_busy[0]), 64'h1);
    chk("x3_data_nb_old", nd(0), 64'h0);
    tick();
    idle();
    #1;
    chk("x3_busy_cleared", 64'(rd_busy[0]), 64'h0);
    chk("x3_busy_cleared_nb", 64'(nb_busy[0]), 64'h0);
    chk("x3_data", dd(0), 64'h5);

    // 5: issue beats writeback; flush beats issue
    set_addr(0, 9); set_addr(1, 10);
    issue_vld = 1; issue_addr = 9;
    wb0_wen = 1; wb0_addr = 9; wb0_data = 64'h99;
    tick();
    idle();
    #1;
    chk("x9_busy_issue_wins", 64'(rd_busy[0]), 64'h1);
    chk("x9_busy_issue_wins_nb", 64'(nb_busy[0]), 64'h1);
    chk("x9_data", dd(0), 64'h99);
    issue_vld = 1; issue_addr = 10; flush = 1;
    tick();
    idle();
    #1;
    chk("x9_flushed", 64'(rd_busy[0]), 64'h0);
    chk("x10_flush_beats_issue", 64'(rd_busy[1]), 64'h0);

    // 6: four ports read independently
    wb0_wen = 1; wb0_addr = 1; wb0_data = 64'h1111;
    wb1_wen = 1; wb1_addr = 2; wb1_data = 64'h2222;
    tick();
    wb0_addr = 3; wb0_data = 64'h3333;
    wb1_addr = 4; wb1_data = 64'h4444;
    tick();
    idle();
    for (int p = 0; p < NP; p++) set_addr(p, p + 1);
    #1;
    chk("mp_p0", dd(0), 64'h1111);
    chk("mp_p1", dd(1), 64'h2222);
    chk("mp_p2", dd(2), 64'h3333);
    chk("mp_p3", dd(3), 64'h4444);
    for (int p = 0; p < NP; p++) set_addr(p, 1);
    #1;
    chk("same_p0", dd(0), 64'h1111);
    chk("same_p3", dd(3), 64'h1111);
    for (int p = 0; p < NP; p++) set_addr(p, p + 1);
    rd_ren = 4'b1010;
    #1;
    chk("ren_p0_off", dd(0), 64'h0);
    chk("ren_p1_on", dd(1), 64'h2222);
    chk("ren_p2_off", dd(2), 64'h0);
    chk("ren_p3_on", dd(3), 64'h4444);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
